preta_conv_pipe: RTL and testbench

PRETA_CONV_PIPE -- requirements
Module: preta_conv_pipe

---
 rtl/preta_conv_pipe.sv | 126 ++++++++++++
 tb/tb_preta_conv_pipe.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/preta_conv_pipe.sv
// 4x4 Winograd input transform Y = BT*X*BT^T over LANES patches per beat.
// Two register stages with valid/ready backpressure and a per-beat bypass.
module preta_conv_pipe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = DATA_W + 2,
  parameter int LANES  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*16*DATA_W-1:0]  in_data,
  input  logic                        in_mode,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*16*ACC_W-1:0]   out_data,
  output logic                        out_last,
  input  logic                        cnt_clr,
  output logic [31:0]                 beat_cnt
);

  localparam int NE = LANES * 16;

  logic s1_valid;
  logic s1_mode;
  logic s1_last;
  logic s2_valid;
  logic s1_load;
  logic s2_load;

  logic signed [ACC_W-1:0] xe    [NE];
  logic signed [ACC_W-1:0] t_nxt [NE];
  logic signed [ACC_W-1:0] s1_t  [NE];
  logic signed [ACC_W-1:0] y_nxt [NE];

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  always_comb begin
    for (int i = 0; i < NE; i++) begin
      xe[i] = ACC_W'($signed(in_data[i*DATA_W +: DATA_W]));
    end
  end

  // Row transform T = BT*X; bypass keeps X as is.
  always_comb begin
    for (int i = 0; i < NE; i++) begin
      t_nxt[i] = xe[i];
    end
    if (!in_mode) begin
      for (int l = 0; l < LANES; l++) begin
        for (int c = 0; c < 4; c++) begin
          t_nxt[l*16+c]    = xe[l*16+c]    - xe[l*16+8+c];
          t_nxt[l*16+4+c]  = xe[l*16+4+c]  + xe[l*16+8+c];
          t_nxt[l*16+8+c]  = xe[l*16+8+c]  - xe[l*16+4+c];
          t_nxt[l*16+12+c] = xe[l*16+4+c]  - xe[l*16+12+c];
        end
      end
    end
  end

  // Column transform Y = T*BT^T.
  always_comb begin
    for (int i = 0; i < NE; i++) begin
      y_nxt[i] = s1_t[i];
    end
    if (!s1_mode) begin
      for (int l = 0; l < LANES; l++) begin
        for (int r = 0; r < 4; r++) begin
          y_nxt[l*16+r*4]   = s1_t[l*16+r*4]   - s1_t[l*16+r*4+2];
          y_nxt[l*16+r*4+1] = s1_t[l*16+r*4+1] + s1_t[l*16+r*4+2];
          y_nxt[l*16+r*4+2] = s1_t[l*16+r*4+2] - s1_t[l*16+r*4+1];
          y_nxt[l*16+r*4+3] = s1_t[l*16+r*4+1] - s1_t[l*16+r*4+3];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load && in_valid) begin
      s1_t <= t_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_mode <= in_mode;
          s1_last <= in_last;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_last <= s1_last;
          for (int i = 0; i < NE; i++) begin
            out_data[i*ACC_W +: ACC_W] <= y_nxt[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (cnt_clr) begin
      beat_cnt <= '0;
    end else if (s2_valid && out_ready) begin
      beat_cnt <= beat_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_preta_conv_pipe.sv
// Scoreboard bench for preta_conv_pipe: directed vectors with hand values,
// plus a stalled random stream checked against a matrix-product model.
module tb_preta_conv_pipe;

  localparam int DW = 16;
  localparam int AW = 18;
  localparam int LN = 4;
  localparam int IW = LN * 16 * DW;
  localparam int OW = LN * 16 * AW;
  localparam int BT [4][4] = '{
    '{1, 0, -1, 0}, '{0, 1, 1, 0}, '{0, -1, 1, 0}, '{0, 1, 0, -1}};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          in_mode;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          cnt_clr;
  logic [31:0]   beat_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int cyc = 0;

  logic [OW-1:0] exp_d [$];
  logic          exp_l [$];
  int            oc [$];

  preta_conv_pipe #(.DATA_W(DW), .ACC_W(AW), .LANES(LN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .cnt_clr(cnt_clr), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", nm, a, e);
    end
  endtask

  task automatic chk_data(input string nm, input logic [OW-1:0] a,
                          input logic [OW-1:0] e);
    logic signed [AW-1:0] va, ve;
    n_cmp++;
    if (a !== e) begin
      n_err++;
      for (int i = 0; i < LN*16; i++) begin
        va = a[i*AW +: AW];
        ve = e[i*AW +: AW];
        if (va !== ve) begin
          $display("FAIL %s elem %0d got %0d want %0d", nm, i, va, ve);
          break;
        end
      end
    end
  endtask

  function automatic logic [IW-1:0] px(input logic [IW-1:0] v,
      input int l, input int r, input int c, input int x);
    v[(l*16+r*4+c)*DW +: DW] = DW'(x);
    return v;
  endfunction

  function automatic logic [OW-1:0] py(input logic [OW-1:0] v,
      input int l, input int r, input int c, input int y);
    v[(l*16+r*4+c)*AW +: AW] = AW'(y);
    return v;
  endfunction

  function automatic logic [OW-1:0] model(input logic [IW-1:0] d,
                                          input logic m);
    logic [OW-1:0] res;
    logic signed [DW-1:0] e;
    int x [4][4];
    int s;
    res = '0;
    for (int l = 0; l < LN; l++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          e = d[(l*16+r*4+c)*DW +: DW];
          x[r][c] = int'(e);
        end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          s = 0;
          if (m) s = x[r][c];
          else
            for (int i = 0; i < 4; i++)
              for (int j = 0; j < 4; j++)
                s += BT[r][i] * x[i][j] * BT[c][j];
          res[(l*16+r*4+c)*AW +: AW] = AW'(s);
        end
    end
    return res;
  endfunction

  task automatic send(input logic [IW-1:0] d, input logic m,
                      input logic l, input logic [OW-1:0] e);
    bit acc = 0;
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    in_mode = m;
    in_last = l;
    while (!acc) begin
      #4;
      acc = in_ready;
      if (acc) begin
        exp_d.push_back(e);
        exp_l.push_back(l);
        n_acc++;
      end
      @(posedge clk);
      if (!acc) begin
        n++;
        if (n > 200) begin
          chk("send_timeout", 1, 0);
          acc = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    forever begin
      @(negedge clk);
      in_valid = 1'b0;
      #4;
      if (exp_d.size() == 0 && !out_valid) break;
      n++;
      if (n > 300) begin
        chk({nm, "_drain_timeout"}, exp_d.size(), 0);
        break;
      end
    end
  endtask

  // Monitor: pops on accepted beats, checks held data during stalls.
  always begin
    @(negedge clk);
    #4;
    if (rst_n && out_valid) begin
      if (exp_d.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else if (out_ready) begin
        chk_data("out_data", out_data, exp_d.pop_front());
        chk("out_last", out_last, exp_l.pop_front());
        oc.push_back(cyc);
      end else begin
        chk_data("stall_data", out_data, exp_d[0]);
        chk("stall_last", out_last, exp_l[0]);
      end
    end
  end

  initial begin
    logic [IW-1:0] x;
    logic [OW-1:0] y;
    int m;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_mode = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_out_data", (out_data == '0), 1);
    chk("rst_out_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    chk("rst_in_ready", in_ready, 1);

    // All ones in lane 0 -> only Y[1][1] = 4; also 2-cycle latency
    x = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) x = px(x, 0, r, c, 1);
    send(x, 1'b0, 1'b1, py('0, 0, 1, 1, 4));
    @(negedge clk);
    in_valid = 1'b0;
    #4;
    chk("lat_c1", out_valid, 0);
    @(negedge clk);
    #4;
    chk("lat_c2", out_valid, 1);
    wait_drain("ones");

    // X[0][0] = l+1 in each lane -> Y[0][0] = l+1 in that lane only
    x = '0;
    y = '0;
    for (int l = 0; l < LN; l++) begin
      x = px(x, l, 0, 0, l + 1);
      y = py(y, l, 0, 0, l + 1);
    end
    send(x, 1'b0, 1'b0, y);
    wait_drain("impulse");

    // Centre 2x2 block = 32767 in lanes 0 and 3: full-range, no wrap
    m = 32767;
    x = '0;
    y = '0;
    for (int k = 0; k < 2; k++) begin
      for (int r = 1; r < 3; r++)
        for (int c = 1; c < 3; c++) x = px(x, 3*k, r, c, m);
      y = py(y, 3*k, 0, 0, m);
      y = py(y, 3*k, 0, 1, -2*m);
      y = py(y, 3*k, 0, 3, -m);
      y = py(y, 3*k, 1, 0, -2*m);
      y = py(y, 3*k, 1, 1, 4*m);
      y = py(y, 3*k, 1, 3, 2*m);
      y = py(y, 3*k, 3, 0, -m);
      y = py(y, 3*k, 3, 1, 2*m);
      y = py(y, 3*k, 3, 3, m);
    end
    send(x, 1'b0, 1'b1, y);
    wait_drain("maxval");

    // Alternating mode back-to-back, X[2][3] = -5
    x = px('0, 0, 2, 3, -5);
    y = '0;
    y = py(y, 0, 0, 3, -5);
    y = py(y, 0, 1, 3, 5);
    y = py(y, 0, 2, 3, 5);
    oc.delete();
    send(x, 1'b0, 1'b0, y);
    send(x, 1'b1, 1'b1, py('0, 0, 2, 3, -5));
    send(x, 1'b0, 1'b1, y);
    send(x, 1'b1, 1'b0, py('0, 0, 2, 3, -5));
    wait_drain("alt");
    chk("alt_count", oc.size(), 4);
    for (int i = 1; i < oc.size(); i++)
      chk("alt_no_bubble", oc[i] - oc[i-1], 1);

    // Stalled stream of 8 random beats
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #4;
    chk("clr_cnt", beat_cnt, 0);
    @(negedge clk);
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int b = 0; b < 8; b++) begin
          logic [IW-1:0] d;
          logic dm;
          logic dl;
          for (int i = 0; i < LN*16; i++)
            d[i*DW +: DW] = DW'($urandom);
          dm = 1'($urandom_range(0, 1));
          dl = 1'($urandom_range(0, 1));
          send(d, dm, dl, model(d, dm));
        end
      end
      begin
        repeat (4) @(negedge clk);
        #4;
        chk("stall_accepted", n_acc, 2);
        chk("stall_in_ready", in_ready, 0);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_drain("stream");
    chk("stream_beat_cnt", beat_cnt, 8);

    // Clear wins over a simultaneous increment
    send(x, 1'b1, 1'b0, py('0, 0, 2, 3, -5));
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #4;
      if (out_valid) break;
    end
    chk("clr_pre_valid", out_valid, 1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #4;
    chk("clr_priority", beat_cnt, 0);
    wait_drain("clr");

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(px('0, 1, 0, 0, 7), 1'b0, 1'b1, py('0, 1, 0, 0, 7));
    send(px('0, 2, 0, 0, 9), 1'b1, 1'b0, py('0, 2, 0, 0, 9));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_d.delete();
    exp_l.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #4;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_beat_cnt", beat_cnt, 0);
    for (int n = 0; n < 4; n++) begin
      chk("mid_rst_no_out", out_valid, 0);
      @(negedge clk);
      #4;
    end

    chk("end_queue_empty", exp_d.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 want 0");
    $fatal(1, "timeout");
  end

endmodule
